// File: rtl/alu_op_decoder.sv
// MIPS ALU control decode: combinational select (0 cycles) plus an En-gated registered copy (1 cycle).
// No backpressure; En=0 holds the registered outputs, and a synchronous reset clears them.
module alu_op_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  input  logic       En,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [2:0] ALUControlQ,
  output logic       IllegalQ,
  output logic       IllegalSticky
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Unsupported R-type functs fall back to ADD so the datapath never sees an undefined select.
  always_comb begin
    ALUControl = CTL_ADD;
    Illegal    = 1'b0;
    case (ALUOp)
      2'b00: ALUControl = CTL_ADD;
      2'b01: ALUControl = CTL_SUB;
      default: begin
        case (Funct)
          FN_ADD:  ALUControl = CTL_ADD;
          FN_SUB:  ALUControl = CTL_SUB;
          FN_AND:  ALUControl = CTL_AND;
          FN_OR:   ALUControl = CTL_OR;
          FN_SLT:  ALUControl = CTL_SLT;
          default: begin
            ALUControl = CTL_ADD;
            Illegal    = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ALUControlQ   <= CTL_AND;
      IllegalQ      <= 1'b0;
      IllegalSticky <= 1'b0;
    end else if (En) begin
      ALUControlQ   <= ALUControl;
      IllegalQ      <= Illegal;
      IllegalSticky <= IllegalSticky | Illegal;
    end
  end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboarded bench for alu_op_decoder: combinational decode sweep plus registered/sticky sequences.
module tb_alu_op_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ALUOp;
  logic [5:0] Funct;
  logic       En;
  logic [2:0] ALUControl;
  logic       Illegal;
  logic [2:0] ALUControlQ;
  logic       IllegalQ;
  logic       IllegalSticky;

  int nvec = 0;
  int nmis = 0;

  logic [3:0] combq[$];  // {illegal, ctl}
  logic [4:0] regq[$];   // {sticky, illegalq, ctlq}

  logic [2:0] m_ctlq;
  logic       m_illq;
  logic       m_sticky;

  alu_op_decoder dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct(Funct), .En(En),
    .ALUControl(ALUControl), .Illegal(Illegal),
    .ALUControlQ(ALUControlQ), .IllegalQ(IllegalQ), .IllegalSticky(IllegalSticky)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the instruction-set table: returns {illegal, ctl}.
  function automatic logic [3:0] ref_dec(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return {1'b0, 3'b010};
    if (op == 2'b01) return {1'b0, 3'b110};
    if (fn == 6'd32) return {1'b0, 3'b010};
    if (fn == 6'd34) return {1'b0, 3'b110};
    if (fn == 6'd36) return {1'b0, 3'b000};
    if (fn == 6'd37) return {1'b0, 3'b001};
    if (fn == 6'd42) return {1'b0, 3'b111};
    return {1'b1, 3'b010};
  endfunction

  task automatic comb(input string tag, input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] e;
    ALUOp = op;
    Funct = fn;
    combq.push_back(ref_dec(op, fn));
    #1;
    e = combq.pop_front();
    chk({tag, "_ctl"}, {5'b0, ALUControl}, {5'b0, e[2:0]});
    chk({tag, "_ill"}, {7'b0, Illegal}, {7'b0, e[3]});
  endtask

  task automatic step(input string tag, input logic r, input logic en,
                      input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] d;
    logic [4:0] e;
    @(negedge clk);
    reset = r;
    En    = en;
    ALUOp = op;
    Funct = fn;
    d = ref_dec(op, fn);
    if (r) begin
      m_ctlq = 3'b000; m_illq = 1'b0; m_sticky = 1'b0;
    end else if (en) begin
      m_ctlq = d[2:0]; m_illq = d[3]; m_sticky = m_sticky | d[3];
    end
    regq.push_back({m_sticky, m_illq, m_ctlq});
    @(posedge clk);
    #1;
    e = regq.pop_front();
    chk({tag, "_ctlq"},   {5'b0, ALUControlQ},   {5'b0, e[2:0]});
    chk({tag, "_illq"},   {7'b0, IllegalQ},      {7'b0, e[3]});
    chk({tag, "_sticky"}, {7'b0, IllegalSticky}, {7'b0, e[4]});
  endtask

  initial begin
    int ill_cnt;
    logic [5:0] rfn[5];
    reset = 1'b1; En = 1'b0; ALUOp = 2'b00; Funct = 6'b0;
    m_ctlq = 3'b000; m_illq = 1'b0; m_sticky = 1'b0;

    step("reset", 1'b1, 1'b0, 2'b10, 6'b000000);

    // Combinational decode with registers held (En=0).
    @(negedge clk);
    reset = 1'b0;
    En    = 1'b0;
    comb("op00", 2'b00, 6'b101010);
    comb("op01", 2'b01, 6'b100000);
    rfn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    foreach (rfn[i]) begin
      comb("rtype10", 2'b10, rfn[i]);
      comb("rtype11", 2'b11, rfn[i]);
    end
    comb("ill_000000", 2'b10, 6'b000000);
    comb("ill_111111", 2'b10, 6'b111111);

    ill_cnt = 0;
    for (int op = 0; op < 4; op++) begin
      for (int fn = 0; fn < 64; fn++) begin
        comb("sweep", op[1:0], fn[5:0]);
        if (op == 2 && Illegal === 1'b1) ill_cnt++;
      end
    end
    chk("illegal_count", ill_cnt[7:0], 8'd59);

    // Registered path, hold, sticky and reset priority.
    step("load_sub",   1'b0, 1'b1, 2'b10, 6'b100010);
    step("hold",       1'b0, 1'b0, 2'b10, 6'b100100);
    step("ill_noen",   1'b0, 1'b0, 2'b10, 6'b000000);
    step("ill_load",   1'b0, 1'b1, 2'b10, 6'b111111);
    step("valid_after",1'b0, 1'b1, 2'b10, 6'b100101);
    step("hold_stick", 1'b0, 1'b0, 2'b01, 6'b000001);
    step("rst_clear",  1'b1, 1'b0, 2'b10, 6'b100000);
    step("first_load", 1'b0, 1'b1, 2'b00, 6'b111111);
    step("ill_again",  1'b0, 1'b1, 2'b11, 6'b000011);
    step("rst_prio",   1'b1, 1'b1, 2'b10, 6'b000000);

    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1) ? rfn[$urandom_range(0, 4)] : 6'($urandom_range(0, 63)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
